// File: rtl/operand_entry_ctrl.sv
// operand_entry_ctrl
//   Front end of the 8-bit adder / hex-display datapath. Synchronises and
//   debounces the active-low ENTER button, then captures two successive SW
//   values as operands A and B and flags them VALID once both are held.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   LOAD_A | waiting for the first press; the next press captures SW into A
//   LOAD_B | A captured; the next press captures SW into B and raises VALID
//   DONE   | both operands valid; the next press drops VALID, operands hold
module operand_entry_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             CLOCK_50,
  input  logic             KEY0,
  input  logic             KEY1,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] OP_A,
  output logic [WIDTH-1:0] OP_B,
  output logic             VALID,
  output logic             LOAD_PULSE,
  output logic [1:0]       PHASE
);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    DONE   = 2'b10
  } phase_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_s1;
  logic             sync_k;
  logic             deb_lvl;
  logic [CNT_W-1:0] deb_cnt;
  logic             deb_accept;
  logic             press;
  phase_t           state;

  // The debounced level flips on the cycle the counter sits at its last value
  // and the input still disagrees; a flip to 0 is a press.
  assign deb_accept = (sync_k != deb_lvl) && (deb_cnt == CNT_LAST);
  assign press      = deb_accept && !sync_k;
  assign PHASE      = state;

  // Two-flop synchroniser; resets to the released (high) level.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      key_s1 <= 1'b1;
      sync_k <= 1'b1;
    end else begin
      key_s1 <= KEY1;
      sync_k <= key_s1;
    end
  end

  // Debounce: count consecutive disagreeing cycles, accept the new level
  // after DEBOUNCE_CYCLES of them; any agreeing cycle restarts the count.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      deb_lvl <= 1'b1;
      deb_cnt <= '0;
    end else if (sync_k == deb_lvl) begin
      deb_cnt <= '0;
    end else if (deb_accept) begin
      deb_lvl <= sync_k;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + CNT_W'(1);
    end
  end

  // Capture sequencer; strobe, operands and phase all move on the press edge.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state      <= LOAD_A;
      OP_A       <= '0;
      OP_B       <= '0;
      VALID      <= 1'b0;
      LOAD_PULSE <= 1'b0;
    end else begin
      LOAD_PULSE <= press;
      if (press) begin
        case (state)
          LOAD_A: begin
            OP_A  <= SW;
            state <= LOAD_B;
          end
          LOAD_B: begin
            OP_B  <= SW;
            VALID <= 1'b1;
            state <= DONE;
          end
          default: begin
            VALID <= 1'b0;
            state <= LOAD_A;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Testbench for operand_entry_ctrl with a short debounce window.
module tb_operand_entry_ctrl;

  localparam int W = 8;
  localparam int D = 4;

  logic         CLOCK_50;
  logic         KEY0;
  logic         KEY1;
  logic [W-1:0] SW;
  logic [W-1:0] OP_A;
  logic [W-1:0] OP_B;
  logic         VALID;
  logic         LOAD_PULSE;
  logic [1:0]   PHASE;

  operand_entry_ctrl #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .KEY0(KEY0),
    .KEY1(KEY1),
    .SW(SW),
    .OP_A(OP_A),
    .OP_B(OP_B),
    .VALID(VALID),
    .LOAD_PULSE(LOAD_PULSE),
    .PHASE(PHASE)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse = -1;
  bit started = 0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Reference model: the button level seen two edges late, accepted once the
  // last D observed values all differ from the current accepted level.
  bit       samp[$];
  bit       win[$];
  bit       deb_m = 1'b1;
  int       ph_m = 0;
  bit [7:0] a_m = '0;
  bit [7:0] b_m = '0;
  bit       v_m = 1'b0;
  bit       p_m = 1'b0;
  bit       m_s;
  bit       m_flip;

  task automatic model_reset();
    samp  = {1'b1, 1'b1};
    win   = {};
    deb_m = 1'b1;
    ph_m  = 0;
    a_m   = '0;
    b_m   = '0;
    v_m   = 1'b0;
    p_m   = 1'b0;
  endtask

  always @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      model_reset();
    end else begin
      samp.push_back(KEY1);
      m_s = samp.pop_front();
      win.push_back(m_s);
      if (win.size() > D) void'(win.pop_front());
      m_flip = (win.size() == D);
      foreach (win[i]) if (win[i] == deb_m) m_flip = 1'b0;
      p_m = 1'b0;
      if (m_flip) begin
        deb_m = ~deb_m;
        if (!deb_m) begin
          p_m = 1'b1;
          case (ph_m)
            0: begin a_m = SW; ph_m = 1; end
            1: begin b_m = SW; v_m = 1'b1; ph_m = 2; end
            default: begin v_m = 1'b0; ph_m = 0; end
          endcase
        end
      end
    end
  end

  // Every-cycle comparison against the model, plus a pulse monitor.
  always @(negedge CLOCK_50) begin
    if (started) begin
      checks++;
      if ({OP_A, OP_B, VALID, LOAD_PULSE, PHASE} !== {a_m, b_m, v_m, p_m, 2'(ph_m)}) begin
        errors++;
        $display("FAIL cycle_%0d: got A=%h B=%h V=%b P=%b PH=%b, want A=%h B=%h V=%b P=%b PH=%0d",
                 cyc, OP_A, OP_B, VALID, LOAD_PULSE, PHASE, a_m, b_m, v_m, p_m, ph_m);
      end
      if (LOAD_PULSE === 1'b1) begin
        pulse_cnt++;
        last_pulse = cyc;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #3;
    end
  endtask

  int p0;
  int fall;
  int rel;

  initial begin
    KEY0 = 1'b0;
    KEY1 = 1'b1;
    SW   = '0;
    @(posedge CLOCK_50);
    started = 1;
    #3;
    tick(3);
    KEY0 = 1'b1;

    // 1: idle after reset
    p0 = pulse_cnt;
    tick(100);
    chk("t1_opa", 32'(OP_A), 32'h00);
    chk("t1_opb", 32'(OP_B), 32'h00);
    chk("t1_valid", 32'(VALID), 32'd0);
    chk("t1_phase", 32'(PHASE), 32'd0);
    chk("t1_nopulse", 32'(pulse_cnt - p0), 32'd0);

    // 2: clean press captures A
    SW = 8'h3C;
    p0 = pulse_cnt;
    KEY1 = 1'b0;
    fall = cyc;
    tick(20);
    chk("t2_count", 32'(pulse_cnt - p0), 32'd1);
    chk("t2_latency", 32'(last_pulse - fall), 32'd6);
    chk("t2_opa", 32'(OP_A), 32'h3C);
    chk("t2_phase", 32'(PHASE), 32'd1);
    KEY1 = 1'b1;
    tick(10);

    // 3: capture B, then wrap back to LOAD_A keeping operands
    SW = 8'hA5;
    KEY1 = 1'b0;
    tick(15);
    chk("t3_opb", 32'(OP_B), 32'hA5);
    chk("t3_valid", 32'(VALID), 32'd1);
    chk("t3_phase", 32'(PHASE), 32'd2);
    KEY1 = 1'b1;
    tick(10);
    SW = 8'h11;
    KEY1 = 1'b0;
    tick(15);
    SW = 8'hFF;
    tick(2);
    chk("t3_wrap_valid", 32'(VALID), 32'd0);
    chk("t3_wrap_phase", 32'(PHASE), 32'd0);
    chk("t3_wrap_opa", 32'(OP_A), 32'h3C);
    chk("t3_wrap_opb", 32'(OP_B), 32'hA5);
    KEY1 = 1'b1;
    tick(10);

    // 4: bouncy press then bouncy release
    SW = 8'h5A;
    p0 = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      KEY1 = (i % 2 == 1);
      tick(2);
    end
    chk("t4_bounce_nopulse", 32'(pulse_cnt - p0), 32'd0);
    KEY1 = 1'b0;
    fall = cyc;
    tick(20);
    chk("t4_count", 32'(pulse_cnt - p0), 32'd1);
    chk("t4_latency", 32'(last_pulse - fall), 32'd6);
    chk("t4_opa", 32'(OP_A), 32'h5A);
    chk("t4_phase", 32'(PHASE), 32'd1);
    p0 = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      KEY1 = (i % 2 == 0);
      tick(2);
    end
    KEY1 = 1'b1;
    tick(30);
    chk("t4_release_nopulse", 32'(pulse_cnt - p0), 32'd0);

    // 5: short glitch is rejected
    p0 = pulse_cnt;
    KEY1 = 1'b0;
    tick(3);
    KEY1 = 1'b1;
    tick(20);
    chk("t5_nopulse", 32'(pulse_cnt - p0), 32'd0);
    chk("t5_phase", 32'(PHASE), 32'd1);

    // 6: reset mid-count in LOAD_B with the button held through release
    SW = 8'hC3;
    KEY1 = 1'b0;
    tick(3);
    KEY0 = 1'b0;
    #1;
    chk("t6_async_opa", 32'(OP_A), 32'h00);
    chk("t6_async_phase", 32'(PHASE), 32'd0);
    chk("t6_async_valid", 32'(VALID), 32'd0);
    tick(3);
    p0 = pulse_cnt;
    KEY0 = 1'b1;
    rel = cyc;
    tick(15);
    chk("t6_count", 32'(pulse_cnt - p0), 32'd1);
    chk("t6_latency", 32'(last_pulse - rel), 32'd6);
    chk("t6_opa", 32'(OP_A), 32'hC3);
    chk("t6_phase", 32'(PHASE), 32'd1);
    KEY1 = 1'b1;
    tick(10);

    // Random presses of varying length with SW churning and occasional resets
    repeat (60) begin
      KEY1 = 1'b0;
      repeat ($urandom_range(1, 8)) begin
        SW = 8'($urandom);
        tick(1);
      end
      KEY1 = 1'b1;
      repeat ($urandom_range(1, 8)) begin
        SW = 8'($urandom);
        tick(1);
      end
      if ($urandom_range(0, 9) == 0) begin
        KEY0 = 1'b0;
        tick($urandom_range(1, 2));
        KEY0 = 1'b1;
      end
    end

    // Random per-cycle bouncing
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) KEY1 = ~KEY1;
      SW = 8'($urandom);
      tick(1);
    end
    KEY1 = 1'b1;
    tick(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
